// File: rtl/clock_time_ctrl_if.sv
// Handshake bundle between the 1Hz/button front end and the clock controller.
// The master drives ticks and button pulses; the slave returns BCD digits, blanking and mode.
interface clock_time_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clr;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic [3:0] hr_lo;
    logic [3:0] hr_hi;
    logic [5:0] blank;
    logic [1:0] mode;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_clr,
        input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, blank, mode
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_clr,
        output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, blank, mode
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// BCD HH:MM:SS timekeeper with RUN / SET_HR / SET_MIN modes, inactivity
// timeout and blinking of the field being edited. All outputs registered.
module clock_time_ctrl #(
    parameter int TIMEOUT_S = 30,
    parameter bit BLINK_EN  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    clock_time_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_e;

    localparam logic [5:0] HR_MASK  = 6'b110000;
    localparam logic [5:0] MIN_MASK = 6'b001100;

    mode_e      r_mode;
    logic [3:0] r_sec_lo, r_sec_hi, r_min_lo, r_min_hi, r_hr_lo, r_hr_hi;
    logic [5:0] r_blank;
    logic       r_phase;
    logic [7:0] r_to;

    logic       w_sec_carry, w_min_carry, w_hr_wrap, w_any_btn, w_to_hit, w_phase_next;
    logic [3:0] w_sec_lo_inc, w_sec_hi_inc, w_min_lo_inc, w_min_hi_inc, w_hr_lo_inc, w_hr_hi_inc;
    logic [7:0] w_to_next;

    // Single-step BCD increments; each field wraps within its own legal range.
    assign w_sec_carry  = (r_sec_lo == 4'd9) && (r_sec_hi == 4'd5);
    assign w_min_carry  = (r_min_lo == 4'd9) && (r_min_hi == 4'd5);
    assign w_hr_wrap    = (r_hr_hi == 4'd2) && (r_hr_lo == 4'd3);
    assign w_sec_lo_inc = (r_sec_lo == 4'd9) ? 4'd0 : r_sec_lo + 4'd1;
    assign w_sec_hi_inc = (r_sec_lo != 4'd9) ? r_sec_hi : ((r_sec_hi == 4'd5) ? 4'd0 : r_sec_hi + 4'd1);
    assign w_min_lo_inc = (r_min_lo == 4'd9) ? 4'd0 : r_min_lo + 4'd1;
    assign w_min_hi_inc = (r_min_lo != 4'd9) ? r_min_hi : ((r_min_hi == 4'd5) ? 4'd0 : r_min_hi + 4'd1);
    assign w_hr_lo_inc  = (w_hr_wrap || r_hr_lo == 4'd9) ? 4'd0 : r_hr_lo + 4'd1;
    assign w_hr_hi_inc  = w_hr_wrap ? 4'd0 : ((r_hr_lo == 4'd9) ? r_hr_hi + 4'd1 : r_hr_hi);

    // A button clears the timeout count before the same-cycle tick is counted.
    assign w_any_btn    = bus.btn_mode | bus.btn_inc | bus.btn_clr;
    assign w_to_next    = (w_any_btn ? 8'd0 : r_to) + {7'd0, bus.tick_1hz};
    assign w_to_hit     = (TIMEOUT_S != 0) && (w_to_next == 8'(TIMEOUT_S));
    assign w_phase_next = r_phase ^ bus.tick_1hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= RUN;
            r_sec_lo <= 4'd0;
            r_sec_hi <= 4'd0;
            r_min_lo <= 4'd0;
            r_min_hi <= 4'd0;
            r_hr_lo  <= 4'd0;
            r_hr_hi  <= 4'd0;
            r_blank  <= 6'd0;
            r_phase  <= 1'b0;
            r_to     <= 8'd0;
        end else begin
            case (r_mode)
                RUN: begin
                    if (bus.tick_1hz) begin
                        r_sec_lo <= w_sec_lo_inc;
                        r_sec_hi <= w_sec_hi_inc;
                        if (w_sec_carry) begin
                            r_min_lo <= w_min_lo_inc;
                            r_min_hi <= w_min_hi_inc;
                            if (w_min_carry) begin
                                r_hr_lo <= w_hr_lo_inc;
                                r_hr_hi <= w_hr_hi_inc;
                            end
                        end
                    end
                    if (bus.btn_mode) r_mode <= SET_HR;
                    r_phase <= 1'b0;
                    r_to    <= 8'd0;
                    r_blank <= 6'd0;
                end
                SET_HR: begin
                    if (bus.btn_mode) begin
                        r_mode  <= SET_MIN;
                        r_phase <= 1'b0;
                        r_to    <= 8'd0;
                        r_blank <= 6'd0;
                    end else begin
                        if (bus.btn_clr) begin
                            r_hr_lo <= 4'd0;
                            r_hr_hi <= 4'd0;
                        end else if (bus.btn_inc) begin
                            r_hr_lo <= w_hr_lo_inc;
                            r_hr_hi <= w_hr_hi_inc;
                        end
                        if (w_to_hit) begin
                            r_mode   <= RUN;
                            r_sec_lo <= 4'd0;
                            r_sec_hi <= 4'd0;
                            r_phase  <= 1'b0;
                            r_to     <= 8'd0;
                            r_blank  <= 6'd0;
                        end else begin
                            r_phase  <= w_phase_next;
                            r_to     <= w_to_next;
                            r_blank  <= (BLINK_EN && w_phase_next) ? HR_MASK : 6'd0;
                        end
                    end
                end
                SET_MIN: begin
                    if (bus.btn_mode || w_to_hit) begin
                        if (!bus.btn_mode) begin
                            if (bus.btn_clr) begin
                                r_min_lo <= 4'd0;
                                r_min_hi <= 4'd0;
                            end else if (bus.btn_inc) begin
                                r_min_lo <= w_min_lo_inc;
                                r_min_hi <= w_min_hi_inc;
                            end
                        end
                        r_mode   <= RUN;
                        r_sec_lo <= 4'd0;
                        r_sec_hi <= 4'd0;
                        r_phase  <= 1'b0;
                        r_to     <= 8'd0;
                        r_blank  <= 6'd0;
                    end else begin
                        if (bus.btn_clr) begin
                            r_min_lo <= 4'd0;
                            r_min_hi <= 4'd0;
                        end else if (bus.btn_inc) begin
                            r_min_lo <= w_min_lo_inc;
                            r_min_hi <= w_min_hi_inc;
                        end
                        r_phase <= w_phase_next;
                        r_to    <= w_to_next;
                        r_blank <= (BLINK_EN && w_phase_next) ? MIN_MASK : 6'd0;
                    end
                end
                default: begin
                    r_mode  <= RUN;
                    r_phase <= 1'b0;
                    r_to    <= 8'd0;
                    r_blank <= 6'd0;
                end
            endcase
        end
    end

    assign bus.sec_lo = r_sec_lo;
    assign bus.sec_hi = r_sec_hi;
    assign bus.min_lo = r_min_lo;
    assign bus.min_hi = r_min_hi;
    assign bus.hr_lo  = r_hr_lo;
    assign bus.hr_hi  = r_hr_hi;
    assign bus.blank  = r_blank;
    assign bus.mode   = r_mode;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed plus random stimulus against a seconds-of-day reference model.
module tb_clock_time_ctrl;
    localparam int TO_S = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    clock_time_ctrl_if bus ();

    clock_time_ctrl #(.TIMEOUT_S(TO_S), .BLINK_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: time as seconds since midnight, mode 0/1/2, blink phase, timeout count.
    int t, mm, ph, tc;

    function automatic logic [23:0] to_bcd(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [5:0] exp_blank();
        if (mm == 0 || ph == 0) return 6'd0;
        return (mm == 1) ? 6'b110000 : 6'b001100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".time"},  {8'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo}, {8'd0, to_bcd(t)});
        chk({tag, ".mode"},  {30'd0, bus.mode}, 32'(mm));
        chk({tag, ".blank"}, {26'd0, bus.blank}, {26'd0, exp_blank()});
    endtask

    task automatic model_reset();
        t = 0; mm = 0; ph = 0; tc = 0;
    endtask

    task automatic model_step(input bit tk, input bit bm, input bit bi, input bit bc);
        int h, m, rest;
        bit btn;
        btn = bm | bi | bc;
        if (mm == 0) begin
            if (tk) t = (t + 1) % 86400;
            if (bm) begin mm = 1; ph = 0; tc = 0; end
        end else if (bm) begin
            if (mm == 2) t = t - (t % 60);
            mm = (mm == 1) ? 2 : 0;
            ph = 0; tc = 0;
        end else begin
            if (mm == 1) begin
                h = t / 3600; rest = t % 3600;
                if (bc) h = 0; else if (bi) h = (h + 1) % 24;
                t = h * 3600 + rest;
            end else begin
                m = (t / 60) % 60; rest = t - m * 60;
                if (bc) m = 0; else if (bi) m = (m + 1) % 60;
                t = rest + m * 60;
            end
            tc = (btn ? 0 : tc) + int'(tk);
            ph = ph ^ int'(tk);
            if (TO_S != 0 && tc == TO_S) begin
                t = t - (t % 60); mm = 0; ph = 0; tc = 0;
            end
        end
    endtask

    task automatic step(input string tag, input bit tk, input bit bm, input bit bi, input bit bc);
        @(negedge clk);
        bus.tick_1hz = tk; bus.btn_mode = bm; bus.btn_inc = bi; bus.btn_clr = bc;
        @(posedge clk);
        model_step(tk, bm, bi, bc);
        #1;
        chk_all(tag);
    endtask

    initial begin
        bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0;
        model_reset();
        #1;
        chk_all("reset");
        #22 rst = 1'b0;

        // 61 ticks from reset
        for (int i = 0; i < 61; i++) step("run61", 1, 0, 0, 0);
        chk("t1.hms", {8'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo}, 32'h000101);

        // preload 23:59:00, then run to 23:59:58 and across midnight
        step("enter_hr", 0, 1, 0, 0);
        step("clr_hr", 0, 0, 0, 1);
        for (int i = 0; i < 23; i++) step("inc_hr", 0, 0, 1, 0);
        step("enter_min", 0, 1, 0, 0);
        step("clr_min", 0, 0, 0, 1);
        for (int i = 0; i < 59; i++) step("inc_min", 0, 0, 1, 0);
        step("exit_run", 0, 1, 0, 0);
        for (int i = 0; i < 58; i++) step("to58", 1, 0, 0, 0);
        chk("t2.pre", {8'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo}, 32'h235958);
        step("tick59", 1, 0, 0, 0);
        chk("t2.59", {8'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo}, 32'h235959);
        step("midnight", 1, 0, 0, 0);
        chk("t2.wrap", {8'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo}, 32'h000000);

        // field wrap without carry: hr 23->00 keeps min, min 59->00 keeps hr
        step("t3.hr", 0, 1, 0, 0);
        for (int i = 0; i < 23; i++) step("t3.inc_hr", 0, 0, 1, 0);
        step("t3.enter_min", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("t3.min5", 0, 0, 1, 0);
        step("t3.back_run", 0, 1, 0, 0);
        step("t3.hr2", 0, 1, 0, 0);
        step("t3.hrwrap", 0, 0, 1, 0);
        chk("t3.hrwrap_hm", {16'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo}, 32'h0005);
        step("t3.min2", 0, 1, 0, 0);
        for (int i = 0; i < 54; i++) step("t3.to59", 0, 0, 1, 0);
        step("t3.minwrap", 0, 0, 1, 0);
        chk("t3.minwrap_hm", {16'd0, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo}, 32'h0000);
        step("t3.exit", 0, 1, 0, 0);

        // priority: mode beats inc; clr in SET_MIN
        for (int i = 0; i < 3; i++) step("t4.run", 1, 0, 0, 0);
        step("t4.mode_inc", 0, 1, 1, 0);
        chk("t4.mode", {30'd0, bus.mode}, 32'd1);
        chk("t4.hr", {24'd0, bus.hr_hi, bus.hr_lo}, 32'h00);
        step("t4.min", 0, 1, 0, 0);
        for (int i = 0; i < 42; i++) step("t4.to42", 0, 0, 1, 0);
        step("t4.clr", 0, 0, 0, 1);
        chk("t4.min0", {24'd0, bus.min_hi, bus.min_lo}, 32'h00);
        step("t4.exit", 0, 1, 0, 0);

        // inactivity timeout from SET_HR with blinking hour field
        for (int i = 0; i < 7; i++) step("t5.run", 1, 0, 0, 0);
        step("t5.enter", 0, 1, 0, 0);
        for (int i = 0; i < TO_S; i++) step("t5.idle", 1, 0, 0, 0);
        chk("t5.mode", {30'd0, bus.mode}, 32'd0);
        chk("t5.sec", {24'd0, bus.sec_hi, bus.sec_lo}, 32'h00);

        // async reset mid-edit
        step("t6.hr", 0, 1, 0, 0);
        step("t6.min", 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step("t6.inc", 0, 0, 1, 0);
        @(negedge clk);
        bus.btn_inc = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all("t6.async");
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
